// File: rtl/pwm_mux_pkg.sv
// pwm_mux_pkg: selector width, OFF code and sequencer state encoding shared by the pwm_mux routing logic
package pwm_mux_pkg;
   localparam int SEL_W = 32;
   localparam logic [SEL_W-1:0] OFF_SEL = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {IDLE, WAIT_SYNC, DEAD} seq_state_t;
endpackage

// File: rtl/pwm_mux_sel_sequencer_dead_time_counter.sv
// dead_time_counter: loadable down-counter that flags the cycle it reads 1; parks at 0 instead of wrapping
module dead_time_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         last
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   assign last = cnt == W'(1);
endmodule

// File: rtl/pwm_mux_sel_sequencer.sv
// pwm_mux_sel_sequencer: owns pwm_mux selector words and applies routing changes break-before-make
module pwm_mux_sel_sequencer
   import pwm_mux_pkg::*;
#(
   parameter int N_OUT        = 24,
   parameter int N_SRC        = 48,
   parameter int DEAD_CYCLES  = 200,
   parameter int SYNC_TIMEOUT = 1000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [7:0]             req_chan,
   input  logic [SEL_W-1:0]       req_sel,
   input  logic                   sync_pulse,
   input  logic                   err_clr,
   output logic [N_OUT*SEL_W-1:0] selector_flat,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int CW = N_OUT > 1 ? $clog2(N_OUT) : 1;
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam int TW = $clog2(SYNC_TIMEOUT + 1);
   seq_state_t state, state_d;
   logic [SEL_W-1:0] sel_r [N_OUT];
   logic [CW-1:0] chan_q;
   logic [SEL_W-1:0] sel_q, cur_sel;
   logic accept, chan_ok, sel_ok, skip, start, reject, sync_hit, timeout, dead_end, dead_last, to_last;
   assign req_ready = state == IDLE;
   assign busy = !req_ready;
   assign accept = req_valid && req_ready;
   assign chan_ok = int'(req_chan) < N_OUT;
   assign sel_ok = req_sel < SEL_W'(N_SRC) || req_sel == OFF_SEL;
   assign cur_sel = chan_ok ? sel_r[req_chan[CW-1:0]] : OFF_SEL;
   assign reject = accept && !(chan_ok && sel_ok);
   assign skip = accept && chan_ok && sel_ok && req_sel == cur_sel;
   assign start = accept && chan_ok && sel_ok && req_sel != cur_sel;
   // a sync coinciding with the final timeout cycle still counts as a sync
   assign sync_hit = state == WAIT_SYNC && sync_pulse;
   assign timeout = state == WAIT_SYNC && !sync_pulse && to_last;
   assign dead_end = state == DEAD && dead_last;
   always_comb begin
      state_d = state;
      if (start) state_d = WAIT_SYNC;
      if (sync_hit) state_d = sel_q == OFF_SEL ? IDLE : DEAD;
      if (timeout || dead_end) state_d = IDLE;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         done <= 1'b0;
         err <= 1'b0;
         chan_q <= '0;
         sel_q <= OFF_SEL;
         for (int k = 0; k < N_OUT; k++) sel_r[k] <= OFF_SEL;
      end else begin
         state <= state_d;
         done <= skip || (sync_hit && sel_q == OFF_SEL) || dead_end;
         err <= reject || timeout || (err && !err_clr);
         if (start) begin
            chan_q <= req_chan[CW-1:0];
            sel_q <= req_sel;
         end
         if (sync_hit) sel_r[chan_q] <= OFF_SEL;
         if (dead_end) sel_r[chan_q] <= sel_q;
      end
   dead_time_counter #(.W(TW)) u_timeout (
      .clk(clk), .rst_n(rst_n), .load(start), .load_val(TW'(SYNC_TIMEOUT)),
      .en(state == WAIT_SYNC), .last(to_last)
   );
   dead_time_counter #(.W(DW)) u_dead (
      .clk(clk), .rst_n(rst_n), .load(sync_hit && sel_q != OFF_SEL), .load_val(DW'(DEAD_CYCLES)),
      .en(state == DEAD), .last(dead_last)
   );
   for (genvar g = 0; g < N_OUT; g++) begin : g_flat
      assign selector_flat[SEL_W*g +: SEL_W] = sel_r[g];
   end
endmodule
